// File: rtl/sw_dram_cmd_ctrl_if.sv
// Command/data bundle between the front-panel sequencer and the Avalon-MM
// write/read masters: control ports (base, length, go, done) and user FIFO ports.
interface sw_dram_cmd_ctrl_if #(
  parameter int unsigned ADDRESSWIDTH = 28,
  parameter int unsigned DATAWIDTH    = 32
);
  logic                    write_control_fixed_location;
  logic [ADDRESSWIDTH-1:0] write_control_write_base;
  logic [ADDRESSWIDTH-1:0] write_control_write_length;
  logic                    write_control_go;
  logic                    write_control_done;
  logic                    write_user_write_buffer;
  logic [DATAWIDTH-1:0]    write_user_buffer_data;
  logic                    write_user_buffer_full;

  logic                    read_control_fixed_location;
  logic [ADDRESSWIDTH-1:0] read_control_read_base;
  logic [ADDRESSWIDTH-1:0] read_control_read_length;
  logic                    read_control_go;
  logic                    read_control_done;
  logic                    read_user_read_buffer;
  logic [DATAWIDTH-1:0]    read_user_buffer_output_data;
  logic                    read_user_data_available;

  // Sequencer side
  modport master (
    output write_control_fixed_location, write_control_write_base,
           write_control_write_length, write_control_go,
           write_user_write_buffer, write_user_buffer_data,
           read_control_fixed_location, read_control_read_base,
           read_control_read_length, read_control_go, read_user_read_buffer,
    input  write_control_done, write_user_buffer_full,
           read_control_done, read_user_buffer_output_data,
           read_user_data_available
  );

  // Avalon-MM master side
  modport slave (
    input  write_control_fixed_location, write_control_write_base,
           write_control_write_length, write_control_go,
           write_user_write_buffer, write_user_buffer_data,
           read_control_fixed_location, read_control_read_base,
           read_control_read_length, read_control_go, read_user_read_buffer,
    output write_control_done, write_user_buffer_full,
           read_control_done, read_user_buffer_output_data,
           read_user_data_available
  );
endinterface

// File: rtl/sw_dram_cmd_ctrl.sv
// Front-panel command sequencer: turns debounced key presses into single-word
// SDRAM write/read transfers and drives the HEX display word and status LEDs.
module sw_dram_cmd_ctrl #(
  parameter int unsigned ADDRESSWIDTH    = 28,
  parameter int unsigned DATAWIDTH       = 32,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned TIMEOUT_CYCLES  = 1048576
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rdwr_cntl,
  input  logic        n_action,
  input  logic        add_data_sel,
  input  logic [15:0] rdwr_address,
  output logic [31:0] display_data,
  output logic        busy,
  output logic        error,
  sw_dram_cmd_ctrl_if.master bus
);

  localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_PUSH = 3'd1,
    WR_GO   = 3'd2,
    WR_WAIT = 3'd3,
    RD_GO   = 3'd4,
    RD_DATA = 3'd5,
    RD_WAIT = 3'd6
  } state_e;

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            stable_q, stable_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            act_q, act_d;

  state_e                  state_q, state_d;
  logic [ADDRESSWIDTH-1:0] addr_q, addr_d;
  logic [31:0]             data_q, data_d;
  logic [31:0]             disp_q, disp_d;
  logic                    err_q, err_d;
  logic                    busy_q, busy_d;
  logic                    first_q, first_d;
  logic [TMO_W-1:0]        tmo_q, tmo_d;
  logic [ADDRESSWIDTH-1:0] len_q, len_d;
  logic                    wr_buf_q, wr_buf_d;
  logic [DATAWIDTH-1:0]    wr_data_q, wr_data_d;
  logic                    wr_go_q, wr_go_d;
  logic                    rd_go_q, rd_go_d;
  logic                    rd_buf_q, rd_buf_d;

  // Synchronise the key, accept a new level only after it has held long enough
  always_comb begin
    sync1_d  = n_action;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    db_cnt_d = '0;
    if (sync2_q != stable_q) begin
      if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
    act_d = stable_q & ~stable_d;
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    disp_d    = disp_q;
    err_d     = err_q;
    first_d   = 1'b0;
    tmo_d     = '0;
    len_d     = ADDRESSWIDTH'(4);
    wr_buf_d  = 1'b0;
    wr_data_d = wr_data_q;
    wr_go_d   = 1'b0;
    rd_go_d   = 1'b0;
    rd_buf_d  = 1'b0;

    if (state_q != IDLE) begin
      tmo_d = tmo_q + TMO_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (act_q) begin
          if (add_data_sel) begin
            addr_d = ADDRESSWIDTH'({rdwr_address, 2'b00});
            disp_d = 32'({rdwr_address, 2'b00});
          end else begin
            err_d = 1'b0;
            if (rdwr_cntl) begin
              data_d  = {data_q[15:0], rdwr_address};
              disp_d  = {data_q[15:0], rdwr_address};
              state_d = WR_PUSH;
            end else begin
              state_d = RD_GO;
            end
          end
        end
      end
      WR_PUSH: begin
        if (!bus.write_user_buffer_full) begin
          wr_buf_d  = 1'b1;
          wr_data_d = DATAWIDTH'(data_q);
          state_d   = WR_GO;
        end
      end
      WR_GO: begin
        wr_go_d = 1'b1;
        first_d = 1'b1;
        state_d = WR_WAIT;
      end
      // The first cycle still sees the idle-level done from before go
      WR_WAIT: begin
        if (!first_q && bus.write_control_done) begin
          state_d = IDLE;
        end
      end
      RD_GO: begin
        rd_go_d = 1'b1;
        state_d = RD_DATA;
      end
      RD_DATA: begin
        if (bus.read_user_data_available) begin
          disp_d   = 32'(bus.read_user_buffer_output_data);
          rd_buf_d = 1'b1;
          first_d  = 1'b1;
          state_d  = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (!first_q && bus.read_control_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort a stuck transfer; the display keeps whatever it showed
    if (state_q != IDLE && tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
      state_d  = IDLE;
      err_d    = 1'b1;
      disp_d   = disp_q;
      first_d  = 1'b0;
      wr_buf_d = 1'b0;
      wr_go_d  = 1'b0;
      rd_go_d  = 1'b0;
      rd_buf_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      stable_q  <= 1'b1;
      db_cnt_q  <= '0;
      act_q     <= 1'b0;
      state_q   <= IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      disp_q    <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      first_q   <= 1'b0;
      tmo_q     <= '0;
      len_q     <= '0;
      wr_buf_q  <= 1'b0;
      wr_data_q <= '0;
      wr_go_q   <= 1'b0;
      rd_go_q   <= 1'b0;
      rd_buf_q  <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      stable_q  <= stable_d;
      db_cnt_q  <= db_cnt_d;
      act_q     <= act_d;
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      disp_q    <= disp_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      first_q   <= first_d;
      tmo_q     <= tmo_d;
      len_q     <= len_d;
      wr_buf_q  <= wr_buf_d;
      wr_data_q <= wr_data_d;
      wr_go_q   <= wr_go_d;
      rd_go_q   <= rd_go_d;
      rd_buf_q  <= rd_buf_d;
    end
  end

  assign display_data = disp_q;
  assign busy         = busy_q;
  assign error        = err_q;

  assign bus.write_control_fixed_location = 1'b0;
  assign bus.write_control_write_base     = addr_q;
  assign bus.write_control_write_length   = len_q;
  assign bus.write_control_go             = wr_go_q;
  assign bus.write_user_write_buffer      = wr_buf_q;
  assign bus.write_user_buffer_data       = wr_data_q;

  assign bus.read_control_fixed_location  = 1'b0;
  assign bus.read_control_read_base       = addr_q;
  assign bus.read_control_read_length     = len_q;
  assign bus.read_control_go              = rd_go_q;
  assign bus.read_user_read_buffer        = rd_buf_q;

endmodule

// File: tb/tb_sw_dram_cmd_ctrl.sv
// Directed bench for sw_dram_cmd_ctrl with a small behavioural model of the
// write/read masters answering go/push/pop at the falling clock edge.
module tb_sw_dram_cmd_ctrl;

  localparam int unsigned AW = 28;
  localparam int unsigned DW = 32;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rdwr_cntl = 1'b0;
  logic        n_action = 1'b1;
  logic        add_data_sel = 1'b0;
  logic [15:0] rdwr_address = '0;
  logic [31:0] display_data;
  logic        busy;
  logic        error;

  sw_dram_cmd_ctrl_if #(.ADDRESSWIDTH(AW), .DATAWIDTH(DW)) bus ();

  sw_dram_cmd_ctrl #(
    .ADDRESSWIDTH(AW), .DATAWIDTH(DW), .DEBOUNCE_CYCLES(8), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk), .reset_n(reset_n), .rdwr_cntl(rdwr_cntl), .n_action(n_action),
    .add_data_sel(add_data_sel), .rdwr_address(rdwr_address),
    .display_data(display_data), .busy(busy), .error(error), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Master model state
  int          cyc = 0;
  int          wr_go_cnt = 0, rd_go_cnt = 0, push_cnt = 0, pop_cnt = 0;
  int          push_cyc = 0, go_cyc = 0;
  logic [31:0] push_data = '0;
  logic        busy_at_go = 1'b0;
  int          wr_t = 0, rd_t = 0, rdd_t = 0;
  logic        wr_hang = 1'b0;
  logic [31:0] rd_word = 32'hCAFEF00D;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      bus.write_control_done       = 1'b1;
      bus.read_control_done        = 1'b1;
      bus.read_user_data_available = 1'b0;
      bus.read_user_buffer_output_data = '0;
      wr_t = 0; rd_t = 0; rdd_t = 0;
    end else begin
      if (bus.write_user_write_buffer) begin
        push_cnt++;
        push_data = bus.write_user_buffer_data;
        push_cyc  = cyc;
      end
      if (bus.write_control_go) begin
        wr_go_cnt++;
        go_cyc     = cyc;
        busy_at_go = busy;
        bus.write_control_done = 1'b0;
        wr_t = wr_hang ? 0 : 3;
      end else if (wr_t > 0) begin
        wr_t--;
        if (wr_t == 0) bus.write_control_done = 1'b1;
      end
      if (bus.read_control_go) begin
        rd_go_cnt++;
        bus.read_control_done = 1'b0;
        rd_t = 3;
      end else if (rd_t > 0) begin
        rd_t--;
        if (rd_t == 0) begin
          bus.read_user_data_available     = 1'b1;
          bus.read_user_buffer_output_data = rd_word;
        end
      end
      if (bus.read_user_read_buffer) begin
        pop_cnt++;
        bus.read_user_data_available = 1'b0;
        rdd_t = 2;
      end else if (rdd_t > 0) begin
        rdd_t--;
        if (rdd_t == 0) bus.read_control_done = 1'b1;
      end
    end
  end

  task automatic do_press(input logic [15:0] sw, input logic sel, input logic rw);
    rdwr_address = sw;
    add_data_sel = sel;
    rdwr_cntl    = rw;
    n_action     = 1'b0;
    repeat (20) @(negedge clk);
    n_action     = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    check_eq(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running want done");
    $fatal(1);
  end

  initial begin
    int g0, p0;
    bus.write_user_buffer_full = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_display", display_data, 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_error", 32'(error), 32'd0);
    check_eq("rst_length", 32'(bus.write_control_write_length), 32'd0);
    check_eq("rst_go", 32'(bus.write_control_go), 32'd0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("wr_length", 32'(bus.write_control_write_length), 32'd4);
    check_eq("rd_length", 32'(bus.read_control_read_length), 32'd4);
    check_eq("fixed_loc", 32'(bus.write_control_fixed_location), 32'd0);

    // Address load
    do_press(16'h0010, 1'b1, 1'b0);
    check_eq("addr_display", display_data, 32'h0000_0040);
    check_eq("addr_wr_base", 32'(bus.write_control_write_base), 32'h40);
    check_eq("addr_rd_base", 32'(bus.read_control_read_base), 32'h40);
    check_eq("addr_no_go", 32'(wr_go_cnt + rd_go_cnt), 32'd0);

    // Two data writes
    do_press(16'hDEAD, 1'b0, 1'b1);
    wait_idle("wr1_idle");
    check_eq("wr1_push_data", push_data, 32'h0000_DEAD);
    do_press(16'hBEEF, 1'b0, 1'b1);
    wait_idle("wr2_idle");
    check_eq("wr2_push_data", push_data, 32'hDEAD_BEEF);
    check_eq("wr2_display", display_data, 32'hDEAD_BEEF);
    check_eq("wr_push_to_go", 32'(go_cyc - push_cyc), 32'd1);
    check_eq("wr_busy_at_go", 32'(busy_at_go), 32'd1);
    check_eq("wr_go_count", 32'(wr_go_cnt), 32'd2);
    check_eq("wr_push_count", 32'(push_cnt), 32'd2);

    // Bounce shorter than the debounce window
    for (int k = 0; k < 5; k++) begin
      n_action = 1'b0;
      repeat (4) @(negedge clk);
      n_action = 1'b1;
      repeat (4) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    check_eq("bounce_busy", 32'(busy), 32'd0);
    check_eq("bounce_go", 32'(wr_go_cnt + rd_go_cnt), 32'd2);
    check_eq("bounce_display", display_data, 32'hDEAD_BEEF);

    // Backpressure, ignored press while busy, timeout
    bus.write_user_buffer_full = 1'b1;
    do_press(16'h1234, 1'b0, 1'b1);
    check_eq("bp_busy", 32'(busy), 32'd1);
    do_press(16'h9999, 1'b0, 1'b0);
    wait_idle("bp_timeout_idle");
    check_eq("bp_error", 32'(error), 32'd1);
    check_eq("bp_no_push", 32'(push_cnt), 32'd2);
    check_eq("bp_no_go", 32'(wr_go_cnt + rd_go_cnt), 32'd2);
    check_eq("bp_display", display_data, 32'hBEEF_1234);
    bus.write_user_buffer_full = 1'b0;

    // Read clears error
    do_press(16'h0000, 1'b0, 1'b0);
    wait_idle("rd_idle");
    check_eq("rd_display", display_data, 32'hCAFE_F00D);
    check_eq("rd_pop_count", 32'(pop_cnt), 32'd1);
    check_eq("rd_go_count", 32'(rd_go_cnt), 32'd1);
    check_eq("rd_error_clr", 32'(error), 32'd0);

    // Top word address
    do_press(16'hFFFF, 1'b1, 1'b0);
    check_eq("wrap_base", 32'(bus.write_control_write_base), 32'h0003_FFFC);
    check_eq("wrap_display", display_data, 32'h0003_FFFC);

    // Reset while waiting on write done
    wr_hang = 1'b1;
    g0 = wr_go_cnt;
    p0 = push_cnt;
    rdwr_address = 16'h5555;
    add_data_sel = 1'b0;
    rdwr_cntl    = 1'b1;
    n_action     = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (wr_go_cnt != g0) break;
      @(negedge clk);
    end
    check_eq("rst_mid_go_seen", 32'(wr_go_cnt - g0), 32'd1);
    check_eq("rst_mid_push", 32'(push_cnt - p0), 32'd1);
    repeat (2) @(negedge clk);
    check_eq("rst_mid_busy_pre", 32'(busy), 32'd1);
    check_eq("rst_mid_disp_pre", display_data, 32'h1234_5555);
    #3 reset_n = 1'b0;
    #1;
    check_eq("rst_mid_busy", 32'(busy), 32'd0);
    check_eq("rst_mid_display", display_data, 32'd0);
    check_eq("rst_mid_base", 32'(bus.write_control_write_base), 32'd0);
    check_eq("rst_mid_wbuf", 32'(bus.write_user_write_buffer), 32'd0);
    check_eq("rst_mid_length", 32'(bus.write_control_write_length), 32'd0);
    n_action = 1'b1;
    wr_hang  = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("post_rst_busy", 32'(busy), 32'd0);
    check_eq("post_rst_length", 32'(bus.read_control_read_length), 32'd4);

    // FSM usable again after reset
    rd_word = 32'h1357_9BDF;
    do_press(16'h0000, 1'b0, 1'b0);
    wait_idle("post_rst_rd_idle");
    check_eq("post_rst_rd_display", display_data, 32'h1357_9BDF);
    check_eq("post_rst_rd_base", 32'(bus.read_control_read_base), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
